// File: rtl/spram_pkg.sv
// -----------------------------------------------------------------------------
// spram_pkg
// Shared definitions for the 16K x 16 single-port RAM model:
//   - geometry localparams (address width, data width, nibble lane count)
//   - lane_slice(): bit range of nibble lane i within a data word
//   - spram_op_t / decode_op(): per-edge operation after applying the
//     RESET > power-off/sleep > standby/deselect > write > read priority
// -----------------------------------------------------------------------------
package spram_pkg;

    localparam int SPRAM_ADDR_W = 14;
    localparam int SPRAM_DATA_W = 16;
    localparam int SPRAM_LANES  = 4;
    localparam int LANE_W       = 4;

    // Bit range [hi:lo] of one nibble lane inside a data word.
    typedef struct packed {
        int unsigned hi;
        int unsigned lo;
    } lane_range_t;

    function automatic lane_range_t lane_slice(input int unsigned i);
        lane_range_t r;
        r.lo = i * LANE_W;
        r.hi = r.lo + LANE_W - 1;
        return r;
    endfunction

    // What a rising edge does, after priority has been resolved.
    typedef enum logic [2:0] {
        OP_RESET,   // DATAOUT cleared, array untouched
        OP_OFF,     // powered off or asleep: DATAOUT cleared, no write
        OP_HOLD,    // standby or deselected: DATAOUT held, no write
        OP_WRITE,   // masked write, DATAOUT held
        OP_READ     // DATAOUT <= mem[ADDRESS]
    } spram_op_t;

    function automatic spram_op_t decode_op(
        input logic reset,
        input logic poweroff_n,
        input logic sleep,
        input logic standby,
        input logic chipselect,
        input logic wren
    );
        if (reset)                     return OP_RESET;
        else if (!poweroff_n || sleep) return OP_OFF;
        else if (standby || !chipselect) return OP_HOLD;
        else if (wren)                 return OP_WRITE;
        else                           return OP_READ;
    endfunction

endpackage

// File: rtl/spram_nibble_lane.sv
// -----------------------------------------------------------------------------
// spram_nibble_lane
// One 4-bit-wide slice of the RAM: a 2**ADDR_W x 4 array with a write enable
// and a registered read port.
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous clear of dout (reset, sleep or power-off)
//   we    - write din into mem[addr] at this edge
//   re    - load dout from mem[addr] (value before this edge)
//   addr  - word address
//   din   - write nibble
//   dout  - registered read nibble; holds when neither clr nor re
// -----------------------------------------------------------------------------
module spram_nibble_lane
    import spram_pkg::*;
#(
    parameter int ADDR_W = SPRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LANE_W-1:0] din,
    output logic [LANE_W-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [LANE_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; only the
    // output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // NOTE: non-blocking assignment means a read in the same edge as a write
    // to the same address returns the old word, matching the RAM primitive.
    always_ff @(posedge clk) begin
        if (clr) begin
            dout <= '0;
        end else if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/spram_16kx16.sv
// -----------------------------------------------------------------------------
// spram_16kx16
// Behavioural model of the iCE40 UltraPlus 256-Kbit single-port RAM:
// 16384 x 16 bits, per-nibble write enables, 1-cycle registered read,
// standby / sleep / power-off controls.
// Ports:
//   CLOCK      - rising-edge clock
//   RESET      - synchronous active-high; clears DATAOUT only
//   ADDRESS    - word address
//   DATAIN     - write data
//   MASKWREN   - nibble write enables, bit i covers DATAIN[4i+3:4i]
//   WREN       - 1 = write, 0 = read
//   CHIPSELECT - 1 = access enabled
//   STANDBY    - 1 = no access, DATAOUT held
//   SLEEP      - 1 = no access, DATAOUT cleared, contents retained
//   POWEROFF   - active low; 0 = array off, DATAOUT cleared
//   DATAOUT    - registered read data
// -----------------------------------------------------------------------------
module spram_16kx16
    import spram_pkg::*;
#(
    parameter int ADDR_WIDTH = SPRAM_ADDR_W,
    parameter int DATA_WIDTH = SPRAM_DATA_W,
    parameter int MASK_WIDTH = DATA_WIDTH / LANE_W
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] DATAIN,
    input  logic [MASK_WIDTH-1:0] MASKWREN,
    input  logic                  WREN,
    input  logic                  CHIPSELECT,
    input  logic                  STANDBY,
    input  logic                  SLEEP,
    input  logic                  POWEROFF,
    output logic [DATA_WIDTH-1:0] DATAOUT
);

    spram_op_t op;
    logic      lane_clr;
    logic      lane_re;
    logic      word_we;

    // One decode shared by every lane keeps the lanes in lock-step.
    always_comb begin
        op       = decode_op(RESET, POWEROFF, SLEEP, STANDBY, CHIPSELECT, WREN);
        lane_clr = (op == OP_RESET) || (op == OP_OFF);
        lane_re  = (op == OP_READ);
        word_we  = (op == OP_WRITE);
    end

    for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_lane
        localparam lane_range_t R = lane_slice(i);

        spram_nibble_lane #(
            .ADDR_W (ADDR_WIDTH)
        ) u_lane (
            .clk  (CLOCK),
            .clr  (lane_clr),
            .we   (word_we && MASKWREN[i]),
            .re   (lane_re),
            .addr (ADDRESS),
            .din  (DATAIN[R.lo +: LANE_W]),
            .dout (DATAOUT[R.lo +: LANE_W])
        );
    end

endmodule

// File: tb/tb_spram_16kx16.sv
// -----------------------------------------------------------------------------
// tb_spram_16kx16
// Self-checking bench for spram_16kx16. Each test task drives one cycle at a
// time; when a cycle has a defined DATAOUT outcome the expected word is pushed
// onto a scoreboard queue and compared after the following rising edge.
// -----------------------------------------------------------------------------
module tb_spram_16kx16;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [13:0] ADDRESS;
    logic [15:0] DATAIN;
    logic [3:0]  MASKWREN;
    logic        WREN;
    logic        CHIPSELECT;
    logic        STANDBY;
    logic        SLEEP;
    logic        POWEROFF;
    logic [15:0] DATAOUT;

    spram_16kx16 dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .ADDRESS    (ADDRESS),
        .DATAIN     (DATAIN),
        .MASKWREN   (MASKWREN),
        .WREN       (WREN),
        .CHIPSELECT (CHIPSELECT),
        .STANDBY    (STANDBY),
        .SLEEP      (SLEEP),
        .POWEROFF   (POWEROFF),
        .DATAOUT    (DATAOUT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------------------------------------------------------- drivers
    task automatic idle();
        RESET      = 1'b0;
        CHIPSELECT = 1'b0;
        WREN       = 1'b0;
        MASKWREN   = 4'h0;
        STANDBY    = 1'b0;
        SLEEP      = 1'b0;
        POWEROFF   = 1'b1;
    endtask

    task automatic set_wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
        CHIPSELECT = 1'b1;
        WREN       = 1'b1;
        ADDRESS    = a;
        DATAIN     = d;
        MASKWREN   = m;
    endtask

    task automatic set_rd(input logic [13:0] a);
        CHIPSELECT = 1'b1;
        WREN       = 1'b0;
        ADDRESS    = a;
        MASKWREN   = 4'h0;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] v);
        exp_q.push_back('{nm, v});
    endtask

    // Advance one edge; the scoreboard entry pushed for this cycle (if any)
    // is compared once DATAOUT has settled after the edge.
    task automatic tick();
        exp_t e;
        @(posedge CLOCK);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (DATAOUT !== e.val)
                $display("FAIL %s: DATAOUT=%h expected %h", e.name, DATAOUT, e.val);
            else
                n_pass++;
        end
        idle();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        RESET = 1'b1; set_rd(14'd0);
        expect_out("reset_clears_dataout", 16'h0000); tick();
        expect_out("idle_holds_zero", 16'h0000); tick();
    endtask

    task automatic test_led_table();
        logic [15:0] tbl [4];
        tbl[0] = 16'h0001; tbl[1] = 16'h0002; tbl[2] = 16'h0004; tbl[3] = 16'h0007;
        for (int i = 0; i < 4; i++) begin
            set_wr(14'(i), tbl[i], 4'hF);
            expect_out("led_write_no_writethrough", 16'h0000); tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_rd(14'(i));
            expect_out($sformatf("led_read_%0d", i), tbl[i]); tick();
        end
    endtask

    task automatic test_nibble_mask();
        set_wr(14'h0100, 16'hFFFF, 4'hF); tick();
        set_wr(14'h0100, 16'h1234, 4'b0101); tick();
        set_rd(14'h0100);
        expect_out("mask_0101", 16'hF2F4); tick();
        set_wr(14'h0100, 16'h0000, 4'h0); tick();
        set_rd(14'h0100);
        expect_out("mask_0000_writes_nothing", 16'hF2F4); tick();
    endtask

    task automatic test_back_to_back();
        set_rd(14'd1);
        expect_out("hazard_pre_read", 16'h0002); tick();
        set_wr(14'd5, 16'hA5A5, 4'hF);
        expect_out("hazard_write_holds_out", 16'h0002); tick();
        set_rd(14'd5);
        expect_out("hazard_read_new_data", 16'hA5A5); tick();
    endtask

    task automatic test_modes();
        set_wr(14'd7, 16'h1234, 4'hF); tick();
        set_rd(14'd0);
        expect_out("modes_pre_read", 16'h0001); tick();
        STANDBY = 1'b1; set_rd(14'd7);
        expect_out("standby_holds", 16'h0001); tick();
        CHIPSELECT = 1'b0; ADDRESS = 14'd7;
        expect_out("deselect_holds", 16'h0001); tick();
        SLEEP = 1'b1; set_rd(14'd7);
        expect_out("sleep_clears", 16'h0000); tick();
        SLEEP = 1'b1; set_wr(14'd7, 16'hFFFF, 4'hF);
        expect_out("sleep_write_out_zero", 16'h0000); tick();
        set_rd(14'd7);
        expect_out("sleep_write_ignored", 16'h1234); tick();
        POWEROFF = 1'b0; set_rd(14'd7);
        expect_out("poweroff_clears", 16'h0000); tick();
    endtask

    task automatic test_reset_mid();
        set_wr(14'd9, 16'h5555, 4'hF); tick();
        set_rd(14'd9);
        expect_out("rst_pre_read", 16'h5555); tick();
        RESET = 1'b1; set_rd(14'd9);
        expect_out("rst_during_read", 16'h0000); tick();
        RESET = 1'b1; set_wr(14'd9, 16'hAAAA, 4'hF);
        expect_out("rst_during_write_out", 16'h0000); tick();
        set_rd(14'd9);
        expect_out("rst_write_suppressed", 16'h5555); tick();
    endtask

    task automatic test_bounds();
        set_wr(14'h3FFF, 16'hBEEF, 4'hF); tick();
        set_wr(14'h0000, 16'h1111, 4'hF); tick();
        set_rd(14'h3FFF);
        expect_out("bound_top", 16'hBEEF); tick();
        set_rd(14'h0000);
        expect_out("bound_zero", 16'h1111); tick();
    endtask

    task automatic test_random_masked();
        logic [15:0] model [16];
        logic [13:0] a;
        logic [15:0] d;
        logic [3:0]  m;
        for (int k = 0; k < 16; k++) begin
            a = 14'h2000 + 14'(k * 37);
            d = 16'($urandom);
            model[k] = d;
            set_wr(a, d, 4'hF); tick();
        end
        for (int k = 0; k < 16; k++) begin
            a = 14'h2000 + 14'(k * 37);
            d = 16'($urandom);
            m = 4'($urandom_range(0, 15));
            for (int l = 0; l < 4; l++)
                if (m[l]) model[k][4*l +: 4] = d[4*l +: 4];
            set_wr(a, d, m); tick();
        end
        for (int k = 0; k < 16; k++) begin
            a = 14'h2000 + 14'(k * 37);
            set_rd(a);
            expect_out($sformatf("rand_read_%0d", k), model[k]); tick();
        end
    endtask

    // -------------------------------------------------------------- sequence
    initial begin
        ADDRESS = '0;
        DATAIN  = '0;
        idle();
        test_reset();
        test_led_table();
        test_nibble_mask();
        test_back_to_back();
        test_modes();
        test_reset_mid();
        test_bounds();
        test_random_masked();
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
